b_ppdu_framer: RTL

B_PPDU_FRAMER -- requirements
Module: b_ppdu_framer

---
 rtl/b_phy_pkg.sv | 34 +++
 rtl/b_crc16.sv | 37 +++
 rtl/b_ppdu_framer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/b_phy_pkg.sv
// b_phy_pkg: shared 802.11b PHY framing constants, FSM states and header payload type.
package b_phy_pkg;

  localparam int unsigned CRC_W          = 16;
  localparam logic [15:0] CRC_POLY       = 16'h1021;
  localparam logic [15:0] CRC_PRESET     = 16'hFFFF;

  localparam logic [15:0] SFD_LONG_DEF   = 16'hF3A0;
  localparam logic [15:0] SFD_SHORT      = 16'h05CF;
  localparam int unsigned SYNC_SHORT_LEN = 56;

  localparam int unsigned SFD_BITS       = 16;
  localparam int unsigned HDR_BITS       = 32;
  localparam int unsigned HDR_CRC_BITS   = 48;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned PLEN_W         = 12;
  localparam int unsigned BYTE_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SFD,
    ST_HDR,
    ST_PSDU
  } state_e;

  // Serial order is LSB first starting at signal_rate bit 0.
  typedef struct packed {
    logic [15:0] length_us;
    logic [7:0]  service;
    logic [7:0]  signal_rate;
  } plcp_hdr_t;

endpackage

// File: rtl/b_crc16.sv
// b_crc16: bit-serial CRC-16 CCITT register with synchronous clear to the preset.
module b_crc16
  import b_phy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic             fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[CRC_W-1] ^ d_i;
    if (clr_i) begin
      crc_d = CRC_PRESET;
    end else if (en_i) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_PRESET;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/b_ppdu_framer.sv
// b_ppdu_framer: serialises SYNC, SFD, PLCP header + CRC and PSDU bytes for the modulator.
// B_FRAMER_SHORT_PREAMBLE_EN adds input short_pre selecting the short preamble.
module b_ppdu_framer
  import b_phy_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 128,
  parameter logic [15:0] SFD_LONG = SFD_LONG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        signal_rate,
  input  logic [7:0]        service,
  input  logic [15:0]       length_us,
  input  logic [PLEN_W-1:0] psdu_len,
`ifdef B_FRAMER_SHORT_PREAMBLE_EN
  input  logic              short_pre,
`endif
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              s_out,
  output logic              mod_en,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  plcp_hdr_t           hdr_q, hdr_d;
  logic                short_q, short_d;
  logic [PLEN_W-1:0]   fetch_left_q, fetch_left_d;
  logic [BYTE_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [BYTE_W-1:0]   sh_q, sh_d;
  logic                s_out_q, s_out_d;
  logic                mod_en_q, mod_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;
  logic                byte_ready_q, byte_ready_d;

  logic                short_sel;
  logic                crc_clr, crc_en, crc_din;
  logic [CRC_W-1:0]    crc_state;
  logic [HDR_BITS-1:0] hdr_bits;
  logic [CNT_W-1:0]    sync_last;
  logic [15:0]         sfd_sel;
  logic [3:0]          crc_idx;
  logic                fin;
  logic                load_byte;

`ifdef B_FRAMER_SHORT_PREAMBLE_EN
  assign short_sel = short_pre;
`else
  assign short_sel = 1'b0;
`endif

  assign hdr_bits = hdr_q;

  b_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .d_i   (crc_din),
    .crc_o (crc_state)
  );

  // Next state describes the bit that will sit on s_out during the following cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    short_d      = short_q;
    fetch_left_d = fetch_left_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    sh_d         = sh_q;
    s_out_d      = 1'b0;
    done_d       = 1'b0;
    underrun_d   = underrun_q;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;
    crc_din      = 1'b0;
    fin          = 1'b0;
    load_byte    = 1'b0;
    sfd_sel      = SFD_LONG;
    crc_idx      = '0;
    sync_last    = short_q ? CNT_W'(SYNC_SHORT_LEN - 1) : CNT_W'(SYNC_LEN - 1);

    if (byte_valid && byte_ready_q) begin
      hold_d       = byte_in;
      hold_full_d  = 1'b1;
      fetch_left_d = fetch_left_q - PLEN_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d             = ST_SYNC;
          cnt_d               = '0;
          hdr_d.signal_rate   = signal_rate;
          hdr_d.service       = service;
          hdr_d.length_us     = length_us;
          short_d             = short_sel;
          fetch_left_d        = psdu_len;
          hold_full_d         = 1'b0;
          underrun_d          = 1'b0;
          crc_clr             = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt_q == sync_last) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SFD: begin
        if (cnt_q == CNT_W'(SFD_BITS - 1)) begin
          state_d = ST_HDR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HDR: begin
        if (cnt_q == CNT_W'(HDR_CRC_BITS - 1)) fin = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_PSDU: begin
        if (cnt_q == CNT_W'(BYTE_W - 1)) fin = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte boundary: next byte must already be held, otherwise the frame ends.
    if (fin) begin
      if (hold_full_q) begin
        state_d     = ST_PSDU;
        cnt_d       = '0;
        load_byte   = 1'b1;
        hold_full_d = 1'b0;
      end else if (fetch_left_q == '0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d    = ST_IDLE;
        underrun_d = 1'b1;
      end
    end

    sfd_sel = short_d ? SFD_SHORT : SFD_LONG;
    crc_idx = 4'(CNT_W'(HDR_CRC_BITS - 1) - cnt_d);

    case (state_d)
      ST_SYNC: s_out_d = ~short_d;
      ST_SFD:  s_out_d = sfd_sel[cnt_d[3:0]];
      ST_HDR: begin
        if (cnt_d < CNT_W'(HDR_BITS)) begin
          s_out_d = hdr_bits[cnt_d[4:0]];
          crc_en  = 1'b1;
          crc_din = hdr_bits[cnt_d[4:0]];
        end else begin
          s_out_d = ~crc_state[crc_idx];
        end
      end
      ST_PSDU: begin
        if (load_byte) begin
          s_out_d = hold_q[0];
          sh_d    = {1'b0, hold_q[BYTE_W-1:1]};
        end else begin
          s_out_d = sh_q[0];
          sh_d    = {1'b0, sh_q[BYTE_W-1:1]};
        end
      end
      default: s_out_d = 1'b0;
    endcase

    mod_en_d     = (state_d != ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    byte_ready_d = ((state_d == ST_SFD) || (state_d == ST_HDR) || (state_d == ST_PSDU)) &&
                   !hold_full_d && (fetch_left_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hdr_q        <= '0;
      short_q      <= 1'b0;
      fetch_left_q <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      sh_q         <= '0;
      s_out_q      <= 1'b0;
      mod_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      byte_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      short_q      <= short_d;
      fetch_left_q <= fetch_left_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      sh_q         <= sh_d;
      s_out_q      <= s_out_d;
      mod_en_q     <= mod_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      byte_ready_q <= byte_ready_d;
    end
  end

  assign s_out      = s_out_q;
  assign mod_en     = mod_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;
  assign byte_ready = byte_ready_q;

endmodule
